// File: rtl/accum_sequencer_if.sv
// rtl/accum_sequencer_if.sv - start/steps, accumulator pins and result handshake bundle for accum_sequencer
interface accum_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
);
    logic             start;
    logic [CNTW-1:0]  steps;
    logic [WIDTH-1:0] acc_q;
    logic             acc_co;
    logic             acc_en_n;
    logic             acc_clr_n;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             result_ready;
    logic             ovf;

    // Requester / datapath / consumer side
    modport master (
        output start, steps, acc_q, acc_co, result_ready,
        input  acc_en_n, acc_clr_n, busy, result, result_valid, ovf
    );

    // Sequencer side
    modport slave (
        input  start, steps, acc_q, acc_co, result_ready,
        output acc_en_n, acc_clr_n, busy, result, result_valid, ovf
    );
endinterface

// File: rtl/accum_sequencer.sv
// rtl/accum_sequencer.sv - accumulator load sequencer (optional ACCSEQ_OVF_ABORT_EN: stop at first carry-out)
module accum_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8,
    parameter int DIV   = 1
) (
    input logic              ck,
    input logic              clr,
    accum_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RUN    = 3'd2,
        SETTLE = 3'd3,
        HOLD   = 3'd4
    } state_t;

    // Prescaler reload value; DIV is limited to 1..255 so it fits 8 bits.
    localparam logic [7:0] PRE_RELOAD = 8'(DIV - 1);
    // When every clock is a load clock the enable stays low across RUN.
    localparam logic       EN_N_AFTER_LOAD = (PRE_RELOAD != 8'd0);

    state_t           state;
    logic [CNTW-1:0]  cnt;
    logic [7:0]       pre;
    logic             en_n;
    logic             clr_n;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             valid;
    logic             ovf;
    logic             stop_now;

    // Last load of the sequence: step count exhausted, or carry seen when aborting.
`ifdef ACCSEQ_OVF_ABORT_EN
    assign stop_now = (cnt == CNTW'(1)) || bus.acc_co;
`else
    assign stop_now = (cnt == CNTW'(1));
`endif

    // Sequencer FSM; every pin driven toward the datapath/consumer is registered here.
    always_ff @(posedge ck or negedge clr) begin
        if (!clr) begin
            state  <= IDLE;
            cnt    <= '0;
            pre    <= '0;
            en_n   <= 1'b1;
            clr_n  <= 1'b1;
            busy   <= 1'b0;
            result <= '0;
            valid  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt   <= bus.steps;
                        ovf   <= 1'b0;
                        clr_n <= 1'b0;
                        busy  <= 1'b1;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    clr_n <= 1'b1;
                    pre   <= PRE_RELOAD;
                    if (cnt == '0) begin
                        en_n  <= 1'b1;
                        state <= SETTLE;
                    end else begin
                        en_n  <= EN_N_AFTER_LOAD;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (pre == 8'd0) begin
                        // Load happens on this edge (enable was low this clock).
                        ovf <= ovf | bus.acc_co;
                        cnt <= cnt - CNTW'(1);
                        pre <= PRE_RELOAD;
                        if (stop_now) begin
                            en_n  <= 1'b1;
                            state <= SETTLE;
                        end else begin
                            en_n  <= EN_N_AFTER_LOAD;
                        end
                    end else begin
                        pre  <= pre - 8'd1;
                        en_n <= (pre != 8'd1);
                    end
                end
                SETTLE: begin
                    // Register output has had a full clock to settle after the last load.
                    result <= bus.acc_q;
                    valid  <= 1'b1;
                    busy   <= 1'b0;
                    state  <= HOLD;
                end
                HOLD: begin
                    if (bus.result_ready) begin
                        valid <= 1'b0;
                        if (bus.start) begin
                            cnt   <= bus.steps;
                            ovf   <= 1'b0;
                            clr_n <= 1'b0;
                            busy  <= 1'b1;
                            state <= CLEAR;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    en_n  <= 1'b1;
                    clr_n <= 1'b1;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.acc_en_n     = en_n;
    assign bus.acc_clr_n    = clr_n;
    assign bus.busy         = busy;
    assign bus.result       = result;
    assign bus.result_valid = valid;
    assign bus.ovf          = ovf;
endmodule

// File: tb/tb_accum_sequencer.sv
// tb/tb_accum_sequencer.sv - self-checking bench for accum_sequencer (DIV=1 and DIV=3 instances)
module tb_accum_sequencer;
    logic ck;
    logic clr;

    logic [1:0] start_s;
    logic [1:0] ready_s;
    logic [7:0] steps_s [2];
    logic [7:0] addend  [2];
    logic [7:0] dreg    [2];

    logic [1:0] en_n_o;
    logic [1:0] clr_n_o;
    logic [1:0] busy_o;
    logic [1:0] valid_o;
    logic [1:0] ovf_o;
    logic [1:0] co;
    logic [7:0] res_o [2];
    logic [8:0] sum0;
    logic [8:0] sum1;

    int loads_tot [2];
    int clrs_tot  [2];
    int checks;
    int errors;

    accum_sequencer_if #(.WIDTH(8), .CNTW(8)) bus0 ();
    accum_sequencer_if #(.WIDTH(8), .CNTW(8)) bus1 ();

    accum_sequencer #(.WIDTH(8), .CNTW(8), .DIV(1)) dut0 (.ck(ck), .clr(clr), .bus(bus0.slave));
    accum_sequencer #(.WIDTH(8), .CNTW(8), .DIV(3)) dut1 (.ck(ck), .clr(clr), .bus(bus1.slave));

    assign sum0 = {1'b0, dreg[0]} + {1'b0, addend[0]};
    assign sum1 = {1'b0, dreg[1]} + {1'b0, addend[1]};
    assign co[0] = sum0[8];
    assign co[1] = sum1[8];

    assign bus0.start        = start_s[0];
    assign bus0.steps        = steps_s[0];
    assign bus0.acc_q        = dreg[0];
    assign bus0.acc_co       = co[0];
    assign bus0.result_ready = ready_s[0];
    assign bus1.start        = start_s[1];
    assign bus1.steps        = steps_s[1];
    assign bus1.acc_q        = dreg[1];
    assign bus1.acc_co       = co[1];
    assign bus1.result_ready = ready_s[1];

    assign en_n_o[0]  = bus0.acc_en_n;
    assign en_n_o[1]  = bus1.acc_en_n;
    assign clr_n_o[0] = bus0.acc_clr_n;
    assign clr_n_o[1] = bus1.acc_clr_n;
    assign busy_o[0]  = bus0.busy;
    assign busy_o[1]  = bus1.busy;
    assign valid_o[0] = bus0.result_valid;
    assign valid_o[1] = bus1.result_valid;
    assign ovf_o[0]   = bus0.ovf;
    assign ovf_o[1]   = bus1.ovf;
    assign res_o[0]   = bus0.result;
    assign res_o[1]   = bus1.result;

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Adder + register datapath (sync clear dominates load) and pulse counters.
    always @(posedge ck) begin
        for (int u = 0; u < 2; u++) begin
            if (clr_n_o[u] === 1'b0) begin
                dreg[u]     <= 8'd0;
                clrs_tot[u] <= clrs_tot[u] + 1;
            end else if (en_n_o[u] === 1'b0) begin
                dreg[u]      <= dreg[u] + addend[u];
                loads_tot[u] <= loads_tot[u] + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start a sequence (READY raised with START so a HOLD unit restarts directly)
    // and check it against an arithmetic model of the accumulation.
    task automatic run_seq(input int u, input int n, input int a, output logic [7:0] exp_res);
        int div;
        int exp_loads;
        int exp_lat;
        int cyc;
        int l0;
        int c0;
        logic exp_ovf;
        div       = (u == 0) ? 1 : 3;
        exp_loads = n;
        exp_ovf   = 1'b0;
        for (int k = 1; k <= n; k++) begin
            if ((k * a) / 256 != ((k - 1) * a) / 256) begin
                exp_ovf = 1'b1;
`ifdef ACCSEQ_OVF_ABORT_EN
                exp_loads = k;
                break;
`endif
            end
        end
        exp_res = 8'((exp_loads * a) % 256);
        exp_lat = 3 + exp_loads * div;

        @(negedge ck);
        addend[u]  = 8'(a);
        steps_s[u] = 8'(n);
        start_s[u] = 1'b1;
        ready_s[u] = 1'b1;
        l0 = loads_tot[u];
        c0 = clrs_tot[u];
        @(posedge ck);
        @(negedge ck);
        start_s[u] = 1'b0;
        ready_s[u] = 1'b0;
        steps_s[u] = 8'($urandom);
        chk("clr_n_after_start", 32'(clr_n_o[u]), 32'd0);
        chk("busy_after_start", 32'(busy_o[u]), 32'd1);
        chk("valid_after_start", 32'(valid_o[u]), 32'd0);
        cyc = 1;
        while (valid_o[u] !== 1'b1 && cyc < 2000) begin
            @(posedge ck);
            cyc++;
            @(negedge ck);
            // A START pulse while the unit is in RUN/SETTLE must be ignored.
            start_s[u] = (cyc == 2);
            if (cyc == 2) steps_s[u] = 8'($urandom);
        end
        start_s[u] = 1'b0;
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("result", 32'(res_o[u]), 32'(exp_res));
        chk("ovf", 32'(ovf_o[u]), 32'(exp_ovf));
        chk("load_pulses", 32'(loads_tot[u] - l0), 32'(exp_loads));
        chk("clr_pulses", 32'(clrs_tot[u] - c0), 32'd1);
        chk("busy_in_hold", 32'(busy_o[u]), 32'd0);
    endtask

    task automatic accept(input int u, input logic [7:0] exp_res);
        @(negedge ck);
        ready_s[u] = 1'b1;
        @(posedge ck);
        @(negedge ck);
        ready_s[u] = 1'b0;
        chk("valid_after_accept", 32'(valid_o[u]), 32'd0);
        chk("result_kept", 32'(res_o[u]), 32'(exp_res));
        chk("busy_idle", 32'(busy_o[u]), 32'd0);
    endtask

    initial begin
        logic [7:0] er;
        int n;
        int a;
        checks     = 0;
        errors     = 0;
        start_s    = 2'b00;
        ready_s    = 2'b00;
        steps_s[0] = 8'd0;
        steps_s[1] = 8'd0;
        addend[0]  = 8'd0;
        addend[1]  = 8'd0;
        clr        = 1'b0;
        repeat (3) @(posedge ck);
        @(negedge ck);
        for (int u = 0; u < 2; u++) begin
            chk("rst_en_n", 32'(en_n_o[u]), 32'd1);
            chk("rst_clr_n", 32'(clr_n_o[u]), 32'd1);
            chk("rst_busy", 32'(busy_o[u]), 32'd0);
            chk("rst_valid", 32'(valid_o[u]), 32'd0);
            chk("rst_result", 32'(res_o[u]), 32'd0);
            chk("rst_ovf", 32'(ovf_o[u]), 32'd0);
        end
        clr = 1'b1;

        run_seq(0, 4, 5, er);
        // HOLD with READY low: result and valid stay put.
        for (int i = 0; i < 10; i++) begin
            @(posedge ck);
            @(negedge ck);
            chk("hold_valid", 32'(valid_o[0]), 32'd1);
            chk("hold_result", 32'(res_o[0]), 32'(er));
        end
        run_seq(0, 0, 9, er);
        accept(0, er);
        run_seq(0, 3, 100, er);
        accept(0, er);
        run_seq(0, 4, 200, er);
        accept(0, er);
        run_seq(1, 3, 1, er);
        accept(1, er);
        run_seq(1, 0, 77, er);

        for (int i = 0; i < 10; i++) begin
            for (int u = 0; u < 2; u++) begin
                n = int'($urandom_range(0, 12));
                a = int'($urandom_range(0, 255));
                run_seq(u, n, a, er);
                if ($urandom_range(0, 1) == 1) accept(u, er);
            end
        end

        // Asynchronous reset in the middle of a RUN.
        run_seq(0, 2, 60, er);
        @(negedge ck);
        addend[1]  = 8'd7;
        steps_s[1] = 8'd8;
        start_s[1] = 1'b1;
        ready_s[1] = 1'b1;
        @(posedge ck);
        @(negedge ck);
        start_s[1] = 1'b0;
        ready_s[1] = 1'b0;
        repeat (4) @(posedge ck);
        #2;
        chk("busy_before_reset", 32'(busy_o[1]), 32'd1);
        clr = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("mid_rst_en_n", 32'(en_n_o[u]), 32'd1);
            chk("mid_rst_clr_n", 32'(clr_n_o[u]), 32'd1);
            chk("mid_rst_busy", 32'(busy_o[u]), 32'd0);
            chk("mid_rst_valid", 32'(valid_o[u]), 32'd0);
            chk("mid_rst_result", 32'(res_o[u]), 32'd0);
            chk("mid_rst_ovf", 32'(ovf_o[u]), 32'd0);
        end
        @(negedge ck);
        clr = 1'b1;
        run_seq(1, 2, 3, er);
        accept(1, er);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
